zxuno_textsink: RTL



---
 rtl/zxuno_textsink.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/zxuno_textsink.sv
// ZXUNO register-bus text sink: CPU byte writes are queued in a FIFO and streamed out over valid/ready.
// Optional build macro TEXTSINK_TERMINATOR_EN turns a written 8'h00 into an end-of-string eol pulse.
module zxuno_textsink #(
   parameter logic [7:0] DATA_ADDR  = 8'hFD,
   parameter logic [7:0] STAT_ADDR  = 8'hFC,
   parameter int         DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] zxuno_addr,
   input  logic       zxuno_regrd,
   input  logic       zxuno_regwr,
   input  logic       regaddr_changed,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       oe_n,
   output logic [7:0] char_out,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       eol
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  writing, stat_writing, rd_seen, wr_block;
   logic [7:0]            wbuf;
   logic [1:0]            sbuf;

   logic empty, full;
   logic data_hit, stat_hit, rd_hit, abort;
   logic data_commit, stat_commit, rd_commit;
   logic is_term, push_req, push_ok, drop, pop, flush;

   // NOTE: pure combinational decode is written as continuous assigns, so no latch can be inferred.
   assign empty       = (count == '0);
   assign full        = (count == CW'(DEPTH));
   assign char_valid  = !empty;
   assign char_out    = mem[rd_ptr];
   assign oe_n        = !(zxuno_addr == STAT_ADDR && zxuno_regrd);

   assign data_hit    = zxuno_regwr && (zxuno_addr == DATA_ADDR) && !wr_block;
   assign stat_hit    = zxuno_regwr && (zxuno_addr == STAT_ADDR) && !wr_block;
   assign rd_hit      = zxuno_regrd && (zxuno_addr == STAT_ADDR);
   assign abort       = regaddr_changed && (zxuno_addr == DATA_ADDR);

   // A write takes effect on the first cycle after its strobe drops.
   assign data_commit = writing && !data_hit && !abort;
   assign stat_commit = stat_writing && !stat_hit;
   assign rd_commit   = rd_seen && !rd_hit;

`ifdef TEXTSINK_TERMINATOR_EN
   assign is_term     = (wbuf == 8'h00);
`else
   assign is_term     = 1'b0;
`endif

   assign flush       = stat_commit && sbuf[0];
   assign pop         = char_valid && char_ready && !flush;
   assign push_req    = data_commit && !is_term;
   assign push_ok     = push_req && (!full || pop);
   assign drop        = push_req && full && !pop;

   // NOTE: every clocked block uses non-blocking assignments so all state updates see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         writing      <= 1'b0;
         stat_writing <= 1'b0;
         rd_seen      <= 1'b0;
         wr_block     <= 1'b1;
         wbuf         <= 8'h00;
         sbuf         <= 2'b00;
      end else begin
         if (abort) begin
            writing <= 1'b0;
         end else if (data_hit) begin
            writing <= 1'b1;
            wbuf    <= din;
         end else begin
            writing <= 1'b0;
         end

         if (stat_hit) begin
            stat_writing <= 1'b1;
            sbuf         <= din[1:0];
         end else begin
            stat_writing <= 1'b0;
         end

         // A strobe still high after an abort or reset must be released before it counts again.
         if (abort && zxuno_regwr)
            wr_block <= 1'b1;
         else if (!zxuno_regwr)
            wr_block <= 1'b0;

         rd_seen <= rd_hit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wbuf;
   end

   // A dropped push wins over any clear arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if ((stat_commit && sbuf[1]) || rd_commit)
         overflow <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dout <= 8'h00;
      else     dout <= {overflow, full, empty, 5'(count)};
   end

`ifdef TEXTSINK_TERMINATOR_EN
   logic eol_pending;

   // Terminators seen while characters are queued wait for the drain; repeats merge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eol         <= 1'b0;
         eol_pending <= 1'b0;
      end else begin
         eol <= 1'b0;
         if (data_commit && is_term) begin
            if (empty) eol         <= 1'b1;
            else       eol_pending <= 1'b1;
         end else if (eol_pending && empty) begin
            eol         <= 1'b1;
            eol_pending <= 1'b0;
         end
      end
   end
`else
   assign eol = 1'b0;
`endif

endmodule
